// File: rtl/neopix_frame_feeder.sv
// neopix_frame_feeder: pixel frame source for the NEOPIX serializer.
// The block keeps a double-buffered array of RGB colours and snapshots it when a frame
// starts. It scales every channel by a global brightness value and streams the pixels as
// GRB words over a valid/ready handshake. After the last pixel it holds the WS2812 latch
// gap and then pulses frame_done.
module neopix_frame_feeder #(
  parameter  int NUM_PIXELS = 3,
  parameter  int CLK_HZ     = 16_000_000,
  parameter  int LATCH_US   = 80,
  localparam int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  localparam int LATCH_CYC  = CLK_HZ / 1_000_000 * LATCH_US
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic          busy,
  output logic          pix_valid,
  output logic [23:0]   pix_data,
  output logic          pix_last,
  input  logic          pix_ready,
  output logic          latch,
  output logic          frame_done
);

  localparam int CW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  localparam int unsigned  LAST_IDX_I  = NUM_PIXELS - 1;
  localparam int unsigned  LATCH_END_I = LATCH_CYC - 1;
  localparam logic [AW-1:0] LAST_IDX   = LAST_IDX_I[AW-1:0];
  localparam logic [CW-1:0] LATCH_END  = LATCH_END_I[CW-1:0];
  localparam logic [AW:0]   NUM_PIX_W  = NUM_PIXELS[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } state_t;

  state_t        state;
  logic [23:0]   back  [NUM_PIXELS];
  logic [23:0]   front [NUM_PIXELS];
  logic [7:0]    bq;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;

  logic          wr_ok;
  logic [AW-1:0] idx_nxt;

  // Channel scale: (c * (b + 1)) >> 8. A brightness of 255 leaves the colour unchanged.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return p[15:8];
  endfunction

  // Scale the RGB input and put the channels in the WS2812 wire order {G,R,B}.
  function automatic logic [23:0] to_grb(input logic [23:0] rgb, input logic [7:0] b);
    return {scale8(rgb[15:8], b), scale8(rgb[23:16], b), scale8(rgb[7:0], b)};
  endfunction

  // Ignore writes above the last pixel. Pre-compute the address of the next pixel.
  always_comb begin
    wr_ok   = ({1'b0, wr_addr} < NUM_PIX_W);
    idx_nxt = idx + 1'b1;
  end

  // Frame sequencer: write port, snapshot, pixel streaming and latch timing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: both pixel buffers are reset on purpose. Until the host writes them, a
      // frame must send black instead of leftover contents. Because of that, the arrays
      // are built from flops rather than RAM.
      for (int i = 0; i < NUM_PIXELS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
      state      <= IDLE;
      bq         <= '0;
      idx        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_last   <= 1'b0;
      latch      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // NOTE: non-blocking assignment makes the snapshot below copy the old back
      // buffer. A write in the same cycle as start therefore reaches only the next frame.
      if (wr_en && wr_ok) back[wr_addr] <= wr_data;

      case (state)
        IDLE: begin
          if (start) begin
            front     <= back;
            bq        <= brightness;
            idx       <= '0;
            pix_data  <= to_grb(back[0], brightness);
            pix_valid <= 1'b1;
            pix_last  <= (NUM_PIXELS == 1);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          if (pix_valid && pix_ready) begin
            if (idx == LAST_IDX) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              cnt       <= '0;
              latch     <= 1'b1;
              state     <= LATCH;
            end else begin
              idx       <= idx_nxt;
              pix_data  <= to_grb(front[idx_nxt], bq);
              pix_last  <= (idx_nxt == LAST_IDX);
            end
          end
        end

        LATCH: begin
          if (cnt == LATCH_END) begin
            latch      <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopix_frame_feeder.sv
// Directed testbench for neopix_frame_feeder at the default parameters
// (3 pixels, 1280-cycle latch). Inputs change and outputs are sampled on the falling edge.
module tb_neopix_frame_feeder;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  brightness;
  logic        start;
  logic        busy;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_last;
  logic        pix_ready;
  logic        latch;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  neopix_frame_feeder dut (
    .CLK        (clk),
    .RST        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .brightness (brightness),
    .start      (start),
    .busy       (busy),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .latch      (latch),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write one pixel. The task is entered on a falling edge and returns on one.
  task automatic write_px(input logic [1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run a frame that has already been started until frame_done, with a bounded wait.
  // Record each accepted word, its pix_last flag, the cycle it was accepted in, the number
  // of latch cycles, and any change of pix_data while it was stalled.
  task automatic run_frame(input bit rnd, output logic [2:0][23:0] w, output logic [2:0] lst,
                           output int nw, output int c_first, output int c_last,
                           output int lat_cyc, output bit fd_seen, output int unstable);
    int          cyc;
    bit          prev_stall;
    logic [23:0] prev_d;
    cyc = 0; prev_stall = 0; prev_d = '0;
    w = '0; lst = '0; nw = 0; c_first = -1; c_last = -1;
    lat_cyc = 0; fd_seen = 0; unstable = 0;
    while (cyc < 3000) begin
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && pix_data !== prev_d) unstable++;
      if (latch === 1'b1) lat_cyc++;
      if (frame_done === 1'b1) begin
        fd_seen = 1;
        break;
      end
      if (pix_valid === 1'b1 && pix_ready) begin
        if (nw < 3) begin
          w[nw]   = pix_data;
          lst[nw] = pix_last;
        end
        if (nw == 0) c_first = cyc;
        c_last = cyc;
        nw++;
      end
      prev_stall = (pix_valid === 1'b1) && !pix_ready;
      prev_d     = pix_data;
      cyc++;
      @(negedge clk);
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b exp 0", latch); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", frame_done); end
    checks++; if (pix_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h exp 000000", pix_data); end
  endtask

  task automatic test_basic();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    write_px(2'd0, 24'hFF0000);
    write_px(2'd1, 24'h00FF00);
    write_px(2'd2, 24'h0000FF);
    brightness = 8'd255;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b exp 1", busy); end
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (nw !== 3) begin errors++; $display("FAIL basic_count: got %0d exp 3", nw); end
    checks++; if (w[0] !== 24'h00FF00) begin errors++; $display("FAIL basic_w0: got %h exp 00ff00", w[0]); end
    checks++; if (w[1] !== 24'hFF0000) begin errors++; $display("FAIL basic_w1: got %h exp ff0000", w[1]); end
    checks++; if (w[2] !== 24'h0000FF) begin errors++; $display("FAIL basic_w2: got %h exp 0000ff", w[2]); end
    checks++; if (lst !== 3'b100) begin errors++; $display("FAIL basic_last: got %b exp 100", lst); end
    checks++; if (cf !== 0 || cl !== 2) begin errors++; $display("FAIL basic_timing: got %0d..%0d exp 0..2", cf, cl); end
    checks++; if (lc !== 1280) begin errors++; $display("FAIL basic_latch_len: got %0d exp 1280", lc); end
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL basic_frame_done: got %b exp 1", fd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b exp 0", busy); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b exp 0", frame_done); end
  endtask

  task automatic test_scaling();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    write_px(2'd0, 24'h808080);
    write_px(2'd1, 24'hFF0000);
    brightness = 8'd127;
    pulse_start();
    brightness = 8'd0;  // brightness is already held for this frame
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w[0] !== 24'h404040) begin errors++; $display("FAIL scale_127_w0: got %h exp 404040", w[0]); end
    checks++; if (w[1] !== 24'h007F00) begin errors++; $display("FAIL scale_127_w1: got %h exp 007f00", w[1]); end
    checks++; if (w[2] !== 24'h00007F) begin errors++; $display("FAIL scale_127_w2: got %h exp 00007f", w[2]); end
    write_px(2'd0, 24'hFFFFFF);
    brightness = 8'd0;
    pulse_start();
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== 72'h0) begin errors++; $display("FAIL scale_0: got %h exp all zero", w); end
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL scale_0_done: got %b exp 1", fd); end
  endtask

  task automatic test_backpressure();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    write_px(2'd0, 24'hAABBCC);
    write_px(2'd1, 24'h010203);
    write_px(2'd2, 24'hFEDCBA);
    brightness = 8'd255;
    pulse_start();
    run_frame(1, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (nw !== 3) begin errors++; $display("FAIL bp_count: got %0d exp 3", nw); end
    checks++; if (w !== {24'hDCFEBA, 24'h020103, 24'hBBAACC}) begin errors++; $display("FAIL bp_words: got %h", w); end
    checks++; if (lst !== 3'b100) begin errors++; $display("FAIL bp_last: got %b exp 100", lst); end
    checks++; if (us !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes exp 0", us); end
    checks++; if (lc !== 1280) begin errors++; $display("FAIL bp_latch_len: got %0d exp 1280", lc); end
  endtask

  task automatic test_buffering();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    pix_ready = 1'b0;
    pulse_start();
    write_px(2'd1, 24'h123456);  // written while the frame is being sent
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== {24'hDCFEBA, 24'h020103, 24'hBBAACC}) begin errors++; $display("FAIL buf_cur_frame: got %h", w); end
    // Start and a write in the same cycle
    start = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 24'h777777;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== {24'hDCFEBA, 24'h341256, 24'hBBAACC}) begin errors++; $display("FAIL buf_start_write: got %h", w); end
    write_px(2'd3, 24'hFFFFFF);  // out-of-range address
    pulse_start();
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== {24'hDCFEBA, 24'h341256, 24'h777777}) begin errors++; $display("FAIL buf_addr3: got %h", w); end
  endtask

  task automatic test_start_ignored();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    int n; bit bad;
    pix_ready = 1'b0;
    pulse_start();
    pulse_start();  // sent again during SEND
    checks++; if (pix_valid !== 1'b1 || pix_data !== 24'h777777) begin errors++; $display("FAIL ign_send: got v=%b d=%h exp v=1 d=777777", pix_valid, pix_data); end
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    pix_ready = 1'b0;
    checks++; if (latch !== 1'b1) begin errors++; $display("FAIL ign_in_latch: got %b exp 1", latch); end
    pulse_start();  // sent again during LATCH
    n = 0;
    while (frame_done !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ign_done_timeout: got %b exp 1", frame_done); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL ign_no_restart: got restart exp none"); end
    // Start held high: the next frame begins on the cycle after frame_done
    start = 1'b1;
    @(negedge clk);
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (fd !== 1'b1) begin errors++; $display("FAIL held_done: got %b exp 1", fd); end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL held_retrigger: got v=%b b=%b exp 1/1", pix_valid, busy); end
    start = 1'b0;
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== {24'hDCFEBA, 24'h341256, 24'h777777} || fd !== 1'b1) begin errors++; $display("FAIL held_frame: got %h done=%b", w, fd); end
  endtask

  task automatic test_reset_mid_send();
    logic [2:0][23:0] w; logic [2:0] lst; int nw, cf, cl, lc, us; bit fd;
    pix_ready = 1'b0;
    pulse_start();
    #2 rst = 1'b1;
    #1;
    checks++; if (pix_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async: got v=%b b=%b exp 0/0", pix_valid, busy); end
    checks++; if (latch !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_async_latch: got l=%b d=%b exp 0/0", latch, frame_done); end
    @(negedge clk);
    rst = 1'b0;
    brightness = 8'd255;
    pulse_start();
    run_frame(0, w, lst, nw, cf, cl, lc, fd, us);
    checks++; if (w !== 72'h0 || nw !== 3) begin errors++; $display("FAIL rst_cleared: got %h n=%0d exp zeros n=3", w, nw); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = '0; start = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_scaling();
    test_backpressure();
    test_buffering();
    test_start_ignored();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
